// File: rtl/seq_divider_if.sv
// Handshake and data bundle for the sequential divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock,
// with optional signed mode, divide-by-zero and MIN/-1 overflow handling.
module seq_divider #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int unsigned     CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             in_ready;
  logic             accept;
  logic             signed_mode;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   trial;

  // Operand conditioning and the trial subtraction of one restoring step
  always_comb begin
    in_ready    = (state_q == IDLE) && !reset;
    accept      = bus.in_valid && in_ready;
    signed_mode = bus.is_signed && SIGNED_EN;
    dvd_neg     = signed_mode && bus.dividend[WIDTH-1];
    dvs_neg     = signed_mode && bus.divisor[WIDTH-1];
    dvd_abs     = dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    dvs_abs     = dvs_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
    trial       = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  end

  // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_pend_d  = dbz_pend_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          neg_quo_d  = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
          cnt_d      = CNT_W'(WIDTH - 1);
          dbz_pend_d = 1'b0;
          ovf_pend_d = 1'b0;
          if (bus.divisor == '0) begin
            quo_d      = '1;
            rem_d      = bus.dividend;
            dbz_pend_d = 1'b1;
            state_d    = FIX;
          end else if (signed_mode && (bus.dividend == MIN_VAL) && (bus.divisor == '1)) begin
            quo_d      = MIN_VAL;
            rem_d      = '0;
            ovf_pend_d = 1'b1;
            state_d    = FIX;
          end else begin
            quo_d   = dvd_abs;
            rem_d   = '0;
            dvs_d   = dvs_abs;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // quo_q doubles as the dividend shift register: its MSB feeds the
        // partial remainder while quotient bits enter at the LSB.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        if (dbz_pend_q || ovf_pend_q) begin
          quotient_d  = quo_q;
          remainder_d = rem_q;
        end else begin
          quotient_d  = neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q;
          remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
        end
        dbz_d   = dbz_pend_q;
        ovf_d   = ovf_pend_q;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_pend_q  <= dbz_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.busy        = (state_q == CALC) || (state_q == FIX);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider at WIDTH=8.
module tb_seq_divider;
  localparam int unsigned W = 8;

  logic clock;
  logic reset;
  int   total;
  int   passed;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider_if #(.WIDTH(W)) bus_u ();

  seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  seq_divider #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clock(clock), .reset(reset), .bus(bus_u)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic       sgn;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Issue one operation, count edges to out_valid (acceptance edge = 1), then handshake
  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input logic sgn,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dbz, output logic ovf, output int lat,
                        output logic acc_ok, output logic rdy_low);
    @(negedge clock);
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    bus.is_signed = sgn;
    bus.in_valid  = 1'b1;
    acc_ok        = bus.in_ready;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 8'h3C;
    bus.divisor  = 8'h00;
    lat     = 1;
    rdy_low = 1'b1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_low = 1'b0;
      @(posedge clock);
      #1;
      lat++;
    end
    if (bus.in_ready) rdy_low = 1'b0;
    q   = bus.quotient;
    r   = bus.remainder;
    dbz = bus.div_by_zero;
    ovf = bus.overflow;
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q, r;
    logic       dbz, ovf, acc_ok, rdy_low;
    logic [7:0] held_q;
    int         lat;

    total  = 0;
    passed = 0;

    vecs[0]  = '{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 1'b0, 10};
    vecs[1]  = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0, 10};
    vecs[2]  = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 1'b0, 10};
    vecs[3]  = '{8'h80,  8'h01,  1'b1, 8'h80,  8'h00,  1'b0, 1'b0, 10};
    vecs[4]  = '{8'h5A,  8'h00,  1'b1, 8'hFF,  8'h5A,  1'b1, 1'b0, 2};
    vecs[5]  = '{8'h5A,  8'h00,  1'b0, 8'hFF,  8'h5A,  1'b1, 1'b0, 2};
    vecs[6]  = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1, 2};
    vecs[7]  = '{8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,  1'b0, 1'b0, 10};
    vecs[8]  = '{8'd100, 8'd10,  1'b0, 8'd10,  8'd0,   1'b0, 1'b0, 10};
    vecs[9]  = '{8'h9C,  8'h07,  1'b1, 8'hF2,  8'hFE,  1'b0, 1'b0, 10};
    vecs[10] = '{8'hFF,  8'h01,  1'b0, 8'hFF,  8'h00,  1'b0, 1'b0, 10};
    vecs[11] = '{8'h80,  8'h00,  1'b1, 8'hFF,  8'h80,  1'b1, 1'b0, 2};
    vecs[12] = '{8'hFF,  8'hFF,  1'b1, 8'h01,  8'h00,  1'b0, 1'b0, 10};

    reset = 1'b1;
    bus.in_valid = 1'b0;  bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0; bus.out_ready = 1'b0;
    bus_u.in_valid = 1'b0; bus_u.is_signed = 1'b0; bus_u.dividend = '0; bus_u.divisor = '0; bus_u.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_quotient", {24'd0, bus.quotient}, 0);
    chk("rst_flags", {30'd0, bus.div_by_zero, bus.overflow}, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, q, r, dbz, ovf, lat, acc_ok, rdy_low);
      chk($sformatf("v%0d_accept", i), {31'd0, acc_ok}, 1);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
      chk($sformatf("v%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
      chk($sformatf("v%0d_div_by_zero", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_overflow", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      chk($sformatf("v%0d_in_ready_low", i), {31'd0, rdy_low}, 1);
    end

    // Backpressure: hold out_ready low, pulse a stray in_valid
    @(negedge clock);
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.is_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("bp_latency", lat, 10);
    held_q = bus.quotient;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.dividend = 8'd10; bus.divisor = 8'd3; bus.in_valid = 1'b1;
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      chk($sformatf("bp_c%0d_out_valid", c), {31'd0, bus.out_valid}, 1);
      chk($sformatf("bp_c%0d_quotient", c), {24'd0, bus.quotient}, 28);
      chk($sformatf("bp_c%0d_remainder", c), {24'd0, bus.remainder}, 4);
      chk($sformatf("bp_c%0d_in_ready", c), {31'd0, bus.in_ready}, 0);
    end
    chk("bp_held_quotient", {24'd0, held_q}, 28);
    @(negedge clock);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release_out_valid", {31'd0, bus.out_valid}, 0);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 1);
    @(posedge clock);
    #1;
    chk("bp_stray_ignored_busy", {31'd0, bus.busy}, 0);
    chk("bp_keep_quotient", {24'd0, bus.quotient}, 28);

    // Reset during CALC iteration 3
    @(negedge clock);
    bus.dividend = 8'd200; bus.divisor = 8'd7; bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("mid_busy_before", {31'd0, bus.busy}, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    chk("mid_rst_quotient", {24'd0, bus.quotient}, 0);
    chk("mid_rst_remainder", {24'd0, bus.remainder}, 0);
    @(negedge clock);
    reset = 1'b0;
    run_op(8'd100, 8'd10, 1'b0, q, r, dbz, ovf, lat, acc_ok, rdy_low);
    chk("post_rst_latency", lat, 10);
    chk("post_rst_quotient", {24'd0, q}, 10);
    chk("post_rst_remainder", {24'd0, r}, 0);

    // SIGNED_EN=0 instance ignores is_signed
    @(negedge clock);
    bus_u.dividend = 8'hF9; bus_u.divisor = 8'h02; bus_u.is_signed = 1'b1; bus_u.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus_u.in_valid = 1'b0;
    lat = 1;
    while (!bus_u.out_valid && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk("unsigned_inst_latency", lat, 10);
    chk("unsigned_inst_quotient", {24'd0, bus_u.quotient}, 124);
    chk("unsigned_inst_remainder", {24'd0, bus_u.remainder}, 1);
    chk("unsigned_inst_flags", {30'd0, bus_u.div_by_zero, bus_u.overflow}, 0);
    @(negedge clock);
    bus_u.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus_u.out_ready = 1'b0;
    chk("unsigned_inst_release", {31'd0, bus_u.in_ready}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multi-cycle radix-2 restoring divider. Successor to the single-cycle integer divider.
- Adds width, a per-operation signed/unsigned mode, valid/ready handshakes on input and output, and explicit divide-by-zero and signed-overflow handling.
- Sits in the arithmetic datapath beside the multiplier. Trades latency for area: one quotient bit is produced per clock.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- SIGNED_EN, 1, 1 = honour is_signed; 0 = is_signed ignored, all operations unsigned.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- is_signed  input  1  1 = two's-complement operands; sampled with the operands.
- dividend  input  WIDTH  numerator.
- divisor  input  WIDTH  denominator.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  quotient, truncated toward zero.
- remainder  output  WIDTH  remainder; sign follows dividend; dividend = divisor*quotient + remainder.
- div_by_zero  output  1  result flag, valid with out_valid.
- overflow  output  1  result flag (signed MIN / -1), valid with out_valid.
- busy  output  1  high in CALC and FIX.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE and the current operation is discarded.
  - quotient, remainder, div_by_zero, overflow, out_valid and busy = 0; in_ready = 1 once reset deasserts.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch operands and the effective mode (is_signed && SIGNED_EN).
  - Store absolute values of the operands (signed mode) and the result signs: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend).
- Special cases, decided at acceptance and taking priority over CALC; next state is FIX:
  - divisor == 0: quotient = all ones, remainder = dividend, div_by_zero = 1.
  - Signed mode, dividend == MIN (1 followed by zeros) and divisor == all ones: quotient = MIN, remainder = 0, overflow = 1.
  - These bypass iteration and the sign correction.
- Otherwise next state is CALC, with an iteration counter at WIDTH-1.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1, trial-subtract |divisor| (WIDTH+1-bit subtractor), set quotient LSB = 1 when non-negative.
  - Counter decrements; leave for FIX after exactly WIDTH iterations.
- FIX:
  - Apply two's-complement negation to quotient/remainder per the stored signs (normal path only).
  - Register the outputs; go to DONE.
- DONE:
  - out_valid = 1; outputs held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE and clear out_valid next cycle.
  - quotient/remainder/flags keep their last values until the next result.
- Latency, measured as rising edges after the acceptance edge until out_valid is seen high:
  - Normal path: WIDTH+2 (WIDTH CALC + FIX + DONE).
  - Special cases: 2.
- in_ready is 0 from the acceptance edge until the cycle after the output handshake. There is no same-cycle re-accept, so throughput is one operation per WIDTH+3 cycles minimum.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- Unsigned mode (is_signed=0 or SIGNED_EN=0): no sign handling; the overflow flag is never set.
- The flags are mutually exclusive. div_by_zero takes priority over the MIN/-1 overflow check.

Test Plan:
- WIDTH=8, unsigned, 200/7 -> after 10 edges out_valid=1, quotient=28, remainder=4, flags 0; in_ready low throughout.
- WIDTH=8, signed, -7/2 -> quotient=-3 (0xFD), remainder=-1 (0xFF). Also 7/-2 -> quotient=0xFD, remainder=1. Also -128/1 -> quotient=0x80, remainder=0.
- WIDTH=8, divisor=0 with dividend=0x5A, signed and unsigned -> out_valid after 2 edges, quotient=0xFF, remainder=0x5A, div_by_zero=1.
- WIDTH=8, signed -128/-1 -> quotient=0x80, remainder=0, overflow=1. The same operands unsigned (128/255) -> quotient=0, remainder=128, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready stays 0; a new in_valid pulse is ignored. Release -> in_ready=1 on the following cycle.
- Assert reset mid-CALC (iteration 3) -> immediately out_valid=0, busy=0, outputs 0. After release, 100/10 completes with quotient=10, remainder=0.
- SIGNED_EN=0 with is_signed=1, 0xF9/0x02 -> quotient=124, remainder=1.
